// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU MEM stage and a
// DMA/loader port. Round-robin on ties, one outstanding transaction at a time,
// and a per-transaction timeout that retires a stuck access with zero data.
module dmem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_ack_o,
    output logic [31:0] dma_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o,
    output logic [15:0] cpu_wait_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DMA = 2'd2
    } state_t;

    // Busy-cycle counter only needs to reach TIMEOUT-1.
    localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic          last_dma;   // 1 when the most recent grant went to DMA
    logic [TW-1:0] tcnt;       // busy cycles already spent on the current access
    logic [31:0]   cpu_hold;   // last load value delivered to the CPU

    logic expire;
    logic ack_cpu;
    logic tmo_cpu;

    // The current busy cycle is the TIMEOUT-th one and memory still has not answered.
    assign expire  = (state != IDLE) && !mem_ack_i && (tcnt == TLAST);
    assign ack_cpu = (state == BUSY_CPU) && mem_ack_i;
    assign tmo_cpu = (state == BUSY_CPU) && expire;

    // CPU is released in the cycle its own access completes or is abandoned.
    assign cpu_stall_o = cpu_req_i && !(ack_cpu || tmo_cpu);

    // Load data is forwarded straight from memory in the completion cycle, then held.
    always_comb begin
        cpu_rdata_o = cpu_hold;
        if (cpu_req_i && tmo_cpu) begin
            cpu_rdata_o = '0;
        end else if (cpu_req_i && ack_cpu && !mem_we_o) begin
            cpu_rdata_o = mem_rdata_i;
        end
    end

    // Arbitration FSM: grant a port, hold the memory request, retire on ack or timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            last_dma    <= 1'b1;
            tcnt        <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            cpu_hold    <= '0;
            dma_rdata_o <= '0;
            dma_ack_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            dma_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (cpu_req_i && (!dma_req_i || last_dma)) begin
                        state       <= BUSY_CPU;
                        last_dma    <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= cpu_we_i;
                        mem_addr_o  <= cpu_addr_i;
                        mem_wdata_o <= cpu_wdata_i;
                    end else if (dma_req_i) begin
                        state       <= BUSY_DMA;
                        last_dma    <= 1'b1;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dma_we_i;
                        mem_addr_o  <= dma_addr_i;
                        mem_wdata_o <= dma_wdata_i;
                    end
                end
                BUSY_CPU, BUSY_DMA: begin
                    if (mem_ack_i || expire) begin
                        // Always pass through IDLE: no re-grant on the retiring edge.
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        tcnt      <= '0;
                        err_o     <= expire;
                        // A requester that dropped its request gets nothing back.
                        if (state == BUSY_CPU) begin
                            if (cpu_req_i && (expire || !mem_we_o)) begin
                                cpu_hold <= expire ? '0 : mem_rdata_i;
                            end
                        end else if (dma_req_i) begin
                            dma_ack_o <= 1'b1;
                            if (expire) begin
                                dma_rdata_o <= '0;
                            end else if (!mem_we_o) begin
                                dma_rdata_o <= mem_rdata_i;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles the CPU spent stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpu_wait_cnt_o <= '0;
        end else if (cpu_stall_o && (cpu_wait_cnt_o != 16'hFFFF)) begin
            cpu_wait_cnt_o <= cpu_wait_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all outputs compared every cycle against a
// transaction-level reference model of the arbiter.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    logic [15:0] cpu_wait_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wdata_i(dma_wdata), .dma_ack_o(dma_ack), .dma_rdata_o(dma_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .err_o(err), .cpu_wait_cnt_o(cpu_wait_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the memory, what was latched, how long it has waited.
    int          m_own  = 0;      // 0 none, 1 CPU, 2 DMA
    int          m_last = 2;      // port granted most recently
    int          m_age  = 0;      // busy cycles already elapsed for the owner
    logic        m_we   = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [31:0] m_hold = '0, m_drd = '0;
    logic        m_dack = 1'b0, m_err = 1'b0;
    logic [15:0] m_wait = '0;

    always @(negedge clk) begin : model
        bit          fin_ack, fin_to, x_stall;
        logic [31:0] x_crd;
        int          win;
        fin_ack = (m_own != 0) && mem_ack;
        fin_to  = (m_own != 0) && !mem_ack && (m_age + 1 == TIMEOUT);
        x_stall = cpu_req && !(m_own == 1 && (fin_ack || fin_to));
        x_crd   = m_hold;
        if (m_own == 1 && cpu_req && fin_to) x_crd = '0;
        else if (m_own == 1 && cpu_req && fin_ack && !m_we) x_crd = mem_rdata;

        chk("m_mem_req",   32'(mem_req),      32'(m_own != 0));
        chk("m_mem_we",    32'(mem_we),       32'(m_we));
        chk("m_mem_addr",  mem_addr,          m_addr);
        chk("m_mem_wdata", mem_wdata,         m_wdata);
        chk("m_stall",     32'(cpu_stall),    32'(x_stall));
        chk("m_cpu_rdata", cpu_rdata,         x_crd);
        chk("m_dma_ack",   32'(dma_ack),      32'(m_dack));
        chk("m_dma_rdata", dma_rdata,         m_drd);
        chk("m_err",       32'(err),          32'(m_err));
        chk("m_wait",      32'(cpu_wait_cnt), 32'(m_wait));

        if (rst) begin
            m_own = 0; m_last = 2; m_age = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_hold = '0; m_drd = '0; m_dack = 1'b0; m_err = 1'b0; m_wait = '0;
        end else begin
            if (x_stall && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
            m_dack = 1'b0;
            m_err  = 1'b0;
            if (m_own == 0) begin
                win = 0;
                if (cpu_req && dma_req) win = (m_last == 1) ? 2 : 1;
                else if (cpu_req)       win = 1;
                else if (dma_req)       win = 2;
                if (win == 1) begin m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata; end
                if (win == 2) begin m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; end
                if (win != 0) begin m_own = win; m_last = win; m_age = 0; end
            end else if (fin_ack || fin_to) begin
                m_err  = fin_to;
                m_hold = x_crd;
                if (m_own == 2 && dma_req) begin
                    m_dack = 1'b1;
                    if (fin_to) m_drd = '0;
                    else if (!m_we) m_drd = mem_rdata;
                end
                m_own = 0;
            end else begin
                m_age++;
            end
        end
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        next_cycle();
        next_cycle();
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_wait", 32'(cpu_wait_cnt), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);

        // CPU load, acked in the first busy cycle
        next_cycle();
        rst = 1'b0;
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8; #2;
        chk("ld_stall_req", 32'(cpu_stall), 32'd1);
        chk("ld_not_yet", 32'(mem_req), 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'd10; #2;
        chk("ld_mem_req", 32'(mem_req), 32'd1);
        chk("ld_mem_addr", mem_addr, 32'h8);
        chk("ld_stall_ack", 32'(cpu_stall), 32'd0);
        chk("ld_rdata", cpu_rdata, 32'd10);
        chk("ld_wait", 32'(cpu_wait_cnt), 32'd1);
        next_cycle();
        cpu_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h55; #2;
        chk("ld_idle", 32'(mem_req), 32'd0);
        chk("ld_hold", cpu_rdata, 32'd10);

        // Ties after reset: CPU first, then DMA wins the second tie
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; #2;
        chk("tie1_stall", 32'(cpu_stall), 32'd1);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'h11; #2;
        chk("tie1_cpu_addr", mem_addr, 32'h100);
        chk("tie1_rdata", cpu_rdata, 32'h11);
        next_cycle();
        mem_ack = 1'b0; cpu_addr = 32'h104; #2;
        chk("tie2_idle", 32'(mem_req), 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'h22; #2;
        chk("tie2_dma_addr", mem_addr, 32'h200);
        chk("tie2_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("tie2_no_ack_yet", 32'(dma_ack), 32'd0);
        next_cycle();
        mem_ack = 1'b0; dma_req = 1'b0; #2;
        chk("tie2_dma_ack", 32'(dma_ack), 32'd1);
        chk("tie2_dma_rdata", dma_rdata, 32'h22);
        chk("tie2_idle_after", 32'(mem_req), 32'd0);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 32'h33; #2;
        chk("tie3_cpu_addr", mem_addr, 32'h104);
        chk("tie3_rdata", cpu_rdata, 32'h33);
        chk("tie3_ack_once", 32'(dma_ack), 32'd0);

        // DMA store, acked in its third busy cycle
        next_cycle();
        mem_ack = 1'b0; cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h14; dma_wdata = 32'd77; #2;
        chk("st_idle", 32'(mem_req), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            dma_addr = 32'hDEAD0000; dma_wdata = 32'h1234;
            mem_ack = (k == 3); mem_rdata = 32'h99; #2;
            chk("st_req", 32'(mem_req), 32'd1);
            chk("st_we", 32'(mem_we), 32'd1);
            chk("st_addr", mem_addr, 32'h14);
            chk("st_wdata", mem_wdata, 32'd77);
            chk("st_ack_early", 32'(dma_ack), 32'd0);
        end
        next_cycle();
        mem_ack = 1'b0; dma_req = 1'b0; #2;
        chk("st_ack", 32'(dma_ack), 32'd1);
        chk("st_dma_rdata", dma_rdata, 32'h22);
        chk("st_cpu_rdata", cpu_rdata, 32'h33);

        // CPU load that memory never answers
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; #2;
        chk("st_ack_once", 32'(dma_ack), 32'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            next_cycle();
            #2;
            chk("to_stall", 32'(cpu_stall), (k < TIMEOUT) ? 32'd1 : 32'd0);
            chk("to_err_early", 32'(err), 32'd0);
        end
        chk("to_rdata", cpu_rdata, 32'd0);
        next_cycle();
        cpu_req = 1'b0; #2;
        chk("to_err", 32'(err), 32'd1);
        chk("to_idle", 32'(mem_req), 32'd0);
        chk("to_hold", cpu_rdata, 32'd0);
        next_cycle();
        #2;
        chk("to_err_once", 32'(err), 32'd0);

        // Reset while a DMA load is in flight (memory acks in that same cycle)
        next_cycle();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80; #2;
        next_cycle();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5A; #2;
        chk("rs_busy", 32'(mem_req), 32'd1);
        next_cycle();
        rst = 1'b0; dma_req = 1'b0; mem_ack = 1'b0; #2;
        chk("rs_mem_req", 32'(mem_req), 32'd0);
        chk("rs_dma_ack", 32'(dma_ack), 32'd0);
        chk("rs_dma_rdata", dma_rdata, 32'd0);
        chk("rs_addr", mem_addr, 32'd0);
        chk("rs_wdata", mem_wdata, 32'd0);
        chk("rs_we", 32'(mem_we), 32'd0);
        chk("rs_err", 32'(err), 32'd0);
        chk("rs_wait", 32'(cpu_wait_cnt), 32'd0);
        chk("rs_cpu_rdata", cpu_rdata, 32'd0);

        // Random traffic: phases differ in how readily memory answers
        for (int ph = 0; ph < 4; ph++) begin
            int p_ack;
            p_ack = (ph == 0) ? 40 : (ph == 1) ? 0 : (ph == 2) ? 90 : 8;
            for (int c = 0; c < 800; c++) begin
                next_cycle();
                rst = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 9) >= 8) cpu_req = 1'($urandom);
                if ($urandom_range(0, 9) >= 8) dma_req = 1'($urandom);
                cpu_we    = 1'($urandom);
                dma_we    = 1'($urandom);
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
                dma_addr  = $urandom;
                dma_wdata = $urandom;
                mem_ack   = ($urandom_range(0, 99) < p_ack);
                mem_rdata = $urandom;
            end
        end

        next_cycle();
        rst = 1'b1;
        next_cycle();
        #6;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 16: the SHALL-abort limit in cycles for an unacknowledged memory transaction.
REQ-003 clk_i  input  1  system clock; all state SHALL change on its rising edge only.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 cpu_req_i  input  1  MEM-stage access request (load or store).
REQ-006 cpu_we_i  input  1  1 = store, 0 = load.
REQ-007 cpu_addr_i  input  32  byte address; cpu_wdata_i  input  32  store data.
REQ-008 cpu_rdata_o  output  32  load data; cpu_stall_o  output  1  freeze IF/ID/EX/MEM.
REQ-009 dma_req_i, dma_we_i  input  1 each; dma_addr_i, dma_wdata_i  input  32 each; loader/debug port.
REQ-010 dma_ack_o  output  1  one-cycle completion pulse; dma_rdata_o  output  32  read data.
REQ-011 mem_req_o, mem_we_o  output  1 each; mem_addr_o, mem_wdata_o  output  32 each; all registered.
REQ-012 mem_rdata_i  input  32; mem_ack_i  input  1  memory completion, valid only while mem_req_o=1.
REQ-013 err_o  output  1  one-cycle timeout pulse; cpu_wait_cnt_o  output  16  CPU stall-cycle count.

Function
REQ-014 States SHALL be IDLE, BUSY_CPU, BUSY_DMA.
REQ-015 IDLE with only one request SHALL grant that port.
REQ-016 IDLE with both requests SHALL grant the port not granted last (round-robin); last_grant resets to DMA, so CPU wins the first tie.
REQ-017 On grant, the block SHALL latch we/addr/wdata of the granted port into the mem_* registers and enter BUSY_x at the next edge with mem_req_o=1.
REQ-018 In BUSY_x, mem_* outputs SHALL hold stable until mem_ack_i=1 or timeout.
REQ-019 On mem_ack_i=1 in BUSY_x, the block SHALL return to IDLE with mem_req_o=0 at the next edge; it SHALL NOT re-grant in that same edge.
REQ-020 Minimum latency: request in cycle N, mem_req_o in N+1, completion in N+1 if mem_ack_i=1 then; there is one IDLE cycle between back-to-back transactions.
REQ-021 cpu_stall_o SHALL be combinational: cpu_req_i AND NOT (state=BUSY_CPU AND mem_ack_i).
REQ-022 cpu_rdata_o SHALL equal mem_rdata_i in the BUSY_CPU ack cycle, and otherwise hold the last captured CPU read value (reset 0).
REQ-023 dma_ack_o SHALL pulse in the BUSY_DMA ack cycle; dma_rdata_o SHALL register mem_rdata_i at that edge.
REQ-024 Store completions SHALL NOT update cpu_rdata_o or dma_rdata_o.
REQ-025 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and its data is discarded (no dma_ack_o pulse, no cpu_rdata_o update).
REQ-026 If BUSY_x lasts TIMEOUT cycles without mem_ack_i, the block SHALL pulse err_o and go to IDLE.
REQ-027 On a CPU timeout, the block SHALL release cpu_stall_o for that cycle with cpu_rdata_o=0.
REQ-028 On a DMA timeout, the block SHALL pulse dma_ack_o with dma_rdata_o=0.
REQ-029 cpu_wait_cnt_o SHALL increment each cycle cpu_stall_o=1 and saturate at 16'hFFFF.
REQ-030 mem_ack_i SHALL be ignored in IDLE.

Reset
REQ-031 rst_i=1 at an edge SHALL force state IDLE and last_grant=DMA.
REQ-032 rst_i=1 at an edge SHALL clear mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, cpu_rdata_o, dma_rdata_o, dma_ack_o, err_o, cpu_wait_cnt_o and the timeout counter.
REQ-033 Reset mid-transaction SHALL abandon the transaction without a completion pulse.
REQ-034 During reset, cpu_stall_o SHALL follow REQ-021 (state=IDLE).

Verification
REQ-035 CPU load only: addr=0x8; mem_ack_i with rdata=10 in the first BUSY cycle -> cpu_stall_o high 1 cycle, cpu_rdata_o=10 in the ack cycle, cpu_wait_cnt_o=1.
REQ-036 Simultaneous CPU/DMA requests after reset -> CPU granted first, then DMA after one IDLE cycle; a second tie grants DMA first.
REQ-037 DMA store addr=0x14 data=77, ack after 3 cycles -> mem_* stable for 3 cycles, dma_ack_o single pulse, cpu_rdata_o unchanged.
REQ-038 No ack for 16 BUSY_CPU cycles -> err_o pulse, cpu_stall_o released, cpu_rdata_o=0, state IDLE.
REQ-039 rst_i asserted during BUSY_DMA -> next edge mem_req_o=0, no dma_ack_o, all outputs at reset values.
